// File: rtl/multi_timer_pkg.sv
// Shared constants for the multi-channel timer: register offsets, CTRL
// field positions and counting-mode encodings.
package multi_timer_pkg;

    // Register offsets within one channel (ADD_I[2:0])
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_PRESET = 3'd1;
    localparam logic [2:0] REG_COUNT  = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_CMP    = 3'd4;

    // CTRL field bit positions
    localparam int CTRL_EN        = 0;
    localparam int CTRL_MODE_LSB  = 1;
    localparam int CTRL_MODE_MSB  = 2;
    localparam int CTRL_IM        = 3;
    localparam int CTRL_PRESC_LSB = 8;
    localparam int CTRL_PRESC_MSB = 15;

    // Counting modes held in CTRL.MODE
    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'b00,
        MODE_RELOAD  = 2'b01,
        MODE_PWM     = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    // Assemble the CTRL read value; unlisted bits read 0
    function automatic logic [31:0] pack_ctrl(input logic en, input mode_e mode,
                                              input logic im, input logic [7:0] presc);
        logic [31:0] v;
        v = '0;
        v[CTRL_EN] = en;
        v[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode;
        v[CTRL_IM] = im;
        v[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = presc;
        return v;
    endfunction

endpackage

// File: rtl/multi_timer_chan.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers, 8-bit prescaler,
// down-counter, sticky expiry flag and (with MULTI_TIMER_PWM_EN) the
// COMPARE register and registered PWM output.
module multi_timer_chan
    import multi_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        wr_en,
    input  logic [2:0]  off,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq_req
`ifdef MULTI_TIMER_PWM_EN
    ,
    output logic        pwm
`endif
);

    logic             en;
    mode_e            mode;
    logic             im;
    logic [7:0]       presc;
    logic [7:0]       presc_cnt;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic             exp_flag;
`ifdef MULTI_TIMER_PWM_EN
    logic [CNT_W-1:0] cmp;
`endif

    logic wr_ctrl, wr_preset, wr_status;
    logic mode_counts, tick, hw_exp, hw_en_clr, en_rise;
    logic unused_wdata;

    assign unused_wdata = ^wdata;

    assign wr_ctrl   = wr_en && (off == REG_CTRL);
    assign wr_preset = wr_en && (off == REG_PRESET);
    assign wr_status = wr_en && (off == REG_STATUS);

    // Which modes advance the counter; reserved modes leave it frozen
    always_comb begin
        mode_counts = 1'b0;
        case (mode)
            MODE_ONESHOT, MODE_RELOAD: mode_counts = 1'b1;
`ifdef MULTI_TIMER_PWM_EN
            MODE_PWM:                  mode_counts = 1'b1;
`endif
            default:                   mode_counts = 1'b0;
        endcase
    end

    // A PRESET write suppresses the tick of that edge
    assign tick      = en && (presc_cnt == presc) && !wr_preset;
    assign hw_exp    = tick && mode_counts && (count == '0);
    assign hw_en_clr = hw_exp && (mode == MODE_ONESHOT);
    assign en_rise   = wr_ctrl && !en && wdata[CTRL_EN];
    assign irq_req   = exp_flag && im;

    // CTRL register; a software write overrides the one-shot EN clear
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            en    <= 1'b0;
            mode  <= MODE_ONESHOT;
            im    <= 1'b0;
            presc <= '0;
        end else if (wr_ctrl) begin
            en    <= wdata[CTRL_EN];
            mode  <= mode_e'(wdata[CTRL_MODE_MSB:CTRL_MODE_LSB]);
            im    <= wdata[CTRL_IM];
            presc <= wdata[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
        end else if (hw_en_clr) begin
            en <= 1'b0;
        end
    end

    // Prescaler: restarts on PRESET write or enable, wraps on tick
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            presc_cnt <= '0;
        end else if (wr_preset || en_rise) begin
            presc_cnt <= '0;
        end else if (en) begin
            presc_cnt <= tick ? 8'd0 : presc_cnt + 8'd1;
        end
    end

    // PRESET register and down-counter with reload
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            preset <= '0;
            count  <= '0;
        end else if (wr_preset) begin
            preset <= wdata[CNT_W-1:0];
            count  <= wdata[CNT_W-1:0];
        end else if (tick && mode_counts) begin
            if (count != '0)
                count <= count - 1'b1;
            else if (mode != MODE_ONESHOT)
                count <= preset;
        end
    end

    // Sticky expiry flag; hardware set beats a same-edge W1C
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I)
            exp_flag <= 1'b0;
        else if (hw_exp)
            exp_flag <= 1'b1;
        else if (wr_status && wdata[0])
            exp_flag <= 1'b0;
    end

`ifdef MULTI_TIMER_PWM_EN
    // COMPARE register and registered PWM output
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            cmp <= '0;
            pwm <= 1'b0;
        end else begin
            if (wr_en && (off == REG_CMP))
                cmp <= wdata[CNT_W-1:0];
            pwm <= en && (count < cmp);
        end
    end
`endif

    // Register read mux, zero-extended to the bus width
    always_comb begin
        rdata = '0;
        case (off)
            REG_CTRL:   rdata = pack_ctrl(en, mode, im, presc);
            REG_PRESET: rdata = 32'(preset);
            REG_COUNT:  rdata = 32'(count);
            REG_STATUS: rdata = {31'd0, exp_flag};
`ifdef MULTI_TIMER_PWM_EN
            REG_CMP:    rdata = 32'(cmp);
`endif
            default:    rdata = '0;
        endcase
    end

endmodule

// File: rtl/multi_timer.sv
// Multi-channel down-counter timer on the bridge bus.
// Optional feature macro: MULTI_TIMER_PWM_EN (PWM mode, COMPARE, PWM_O).
// Bus: a write takes effect on the CLK_I edge where WE_I is high; there is
// no wait state or ready. DAT_O is combinational from ADD_I.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter  int NCH   = 2,
    parameter  int CNT_W = 32,
    localparam int AW    = $clog2(NCH) + 3
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          WE_I,
    input  logic [AW-1:0] ADD_I,
    input  logic [31:0]   DAT_I,
    output logic [31:0]   DAT_O,
    output logic          IRQ
`ifdef MULTI_TIMER_PWM_EN
    ,
    output logic [NCH-1:0] PWM_O
`endif
);

    logic [31:0]    add_ext;
    logic [28:0]    ch_idx;
    logic [2:0]     off;
    logic [31:0]    chan_rdata [NCH];
    logic [NCH-1:0] irq_req;

    assign add_ext = 32'(ADD_I);
    assign ch_idx  = add_ext[31:3];
    assign off     = ADD_I[2:0];

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        multi_timer_chan #(.CNT_W(CNT_W)) u_chan (
            .CLK_I   (CLK_I),
            .RST_I   (RST_I),
            .wr_en   (WE_I && (ch_idx == 29'(i))),
            .off     (off),
            .wdata   (DAT_I),
            .rdata   (chan_rdata[i]),
            .irq_req (irq_req[i])
`ifdef MULTI_TIMER_PWM_EN
            ,
            .pwm     (PWM_O[i])
`endif
        );
    end

    // Channel select for reads; out-of-range channels read 0
    always_comb begin
        DAT_O = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_idx == 29'(i))
                DAT_O = chan_rdata[i];
        end
    end

    // Level interrupt: registered OR of unmasked expiry flags
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I)
            IRQ <= 1'b0;
        else
            IRQ <= |irq_req;
    end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer (NCH=2, CNT_W=32).
module tb_multi_timer;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        WE_I;
  logic [3:0]  ADD_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        IRQ;
`ifdef MULTI_TIMER_PWM_EN
  logic [1:0]  PWM_O;
`endif

  int checks = 0;
  int errors = 0;

  multi_timer #(.NCH(2), .CNT_W(32)) dut (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .WE_I  (WE_I),
    .ADD_I (ADD_I),
    .DAT_I (DAT_I),
    .DAT_O (DAT_O),
    .IRQ   (IRQ)
`ifdef MULTI_TIMER_PWM_EN
    ,
    .PWM_O (PWM_O)
`endif
  );

  // clock / reset
  always #5 CLK_I = ~CLK_I;

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  function automatic logic [3:0] addr(input int ch, input int off);
    return 4'(ch * 8 + off);
  endfunction

  task automatic step();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    WE_I  = 1'b1;
    ADD_I = a;
    DAT_I = d;
    step();
    WE_I  = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    ADD_I = a;
    #1;
    d = DAT_O;
  endtask

  logic [31:0] rd;

  initial begin
    RST_I = 1'b1;
    WE_I  = 1'b0;
    ADD_I = '0;
    DAT_I = '0;
    repeat (2) step();
    check("irq_in_reset", {31'd0, IRQ}, 32'd0);
    RST_I = 1'b0;
    step();

    // reset values of every offset on both channels
    for (int ch = 0; ch < 2; ch++) begin
      for (int off = 0; off < 8; off++) begin
        bus_read(addr(ch, off), rd);
        check($sformatf("reset_ch%0d_off%0d", ch, off), rd, 32'd0);
        step();
      end
    end
    check("irq_after_reset", {31'd0, IRQ}, 32'd0);

    // ch0 one-shot, PRESET=3, IM set
    bus_write(addr(0, 1), 32'd3);
    bus_write(addr(0, 0), 32'h9);
    bus_read(addr(0, 2), rd); check("os_count3", rd, 32'd3);
    step(); bus_read(addr(0, 2), rd); check("os_count2", rd, 32'd2);
    step(); bus_read(addr(0, 2), rd); check("os_count1", rd, 32'd1);
    step(); bus_read(addr(0, 2), rd); check("os_count0", rd, 32'd0);
    bus_read(addr(0, 3), rd); check("os_exp_before", rd, 32'd0);
    step();
    bus_read(addr(0, 3), rd); check("os_exp_set", rd, 32'd1);
    bus_read(addr(0, 0), rd); check("os_en_cleared", rd, 32'h8);
    check("os_irq_lag", {31'd0, IRQ}, 32'd0);
    step();
    check("os_irq_high", {31'd0, IRQ}, 32'd1);
    bus_read(addr(0, 2), rd); check("os_count_stays0", rd, 32'd0);
    bus_write(addr(0, 3), 32'd1);
    check("os_irq_still_reg", {31'd0, IRQ}, 32'd1);
    bus_read(addr(0, 3), rd); check("os_exp_cleared", rd, 32'd0);
    step();
    check("os_irq_low", {31'd0, IRQ}, 32'd0);

    // ch1 auto-reload, PRESET=2, PRESC=4, masked: period 15
    bus_write(addr(1, 1), 32'd2);
    bus_write(addr(1, 0), 32'h0403);
    repeat (14) step();
    bus_read(addr(1, 3), rd); check("rl_exp_e14", rd, 32'd0);
    step();
    bus_read(addr(1, 3), rd); check("rl_exp_e15", rd, 32'd1);
    bus_read(addr(1, 2), rd); check("rl_reload", rd, 32'd2);
    check("rl_irq_masked", {31'd0, IRQ}, 32'd0);
    bus_write(addr(1, 3), 32'd1);
    bus_read(addr(1, 3), rd); check("rl_w1c", rd, 32'd0);
    repeat (13) step();
    bus_read(addr(1, 3), rd); check("rl_exp_e29", rd, 32'd0);
    step();
    bus_read(addr(1, 3), rd); check("rl_exp_e30", rd, 32'd1);
    check("rl_irq_masked2", {31'd0, IRQ}, 32'd0);
    bus_write(addr(1, 0), 32'h040B);
    check("rl_irq_lag", {31'd0, IRQ}, 32'd0);
    step();
    check("rl_irq_unmasked", {31'd0, IRQ}, 32'd1);

    // hardware set coincident with W1C: set wins (next expiry at E45)
    bus_write(addr(1, 3), 32'd1);
    repeat (11) step();
    bus_read(addr(1, 3), rd); check("coinc_before", rd, 32'd0);
    bus_write(addr(1, 3), 32'd1);
    bus_read(addr(1, 3), rd); check("coinc_set_wins", rd, 32'd1);
    bus_write(addr(1, 0), 32'h0);
    bus_write(addr(1, 3), 32'd1);
    step();
    check("coinc_irq_clear", {31'd0, IRQ}, 32'd0);

    // PRESET write mid-count reloads COUNT and restarts the prescaler
    bus_write(addr(0, 1), 32'd10);
    bus_write(addr(0, 0), 32'h0201);
    repeat (4) step();
    bus_read(addr(0, 2), rd); check("mid_count9", rd, 32'd9);
    bus_write(addr(0, 1), 32'd100);
    bus_read(addr(0, 2), rd); check("mid_count100", rd, 32'd100);
    step(); step();
    bus_read(addr(0, 2), rd); check("mid_presc_restart", rd, 32'd100);
    step();
    bus_read(addr(0, 2), rd); check("mid_count99", rd, 32'd99);
    bus_write(addr(0, 0), 32'h0);

    // CTRL unused bits read 0; COUNT and reserved offsets ignore writes
    bus_write(addr(0, 1), 32'd5);
    bus_write(addr(0, 0), 32'hFFFF_FFFF);
    bus_read(addr(0, 0), rd); check("ctrl_mask", rd, 32'h0000_FF0F);
    bus_write(addr(0, 0), 32'h0);
    bus_write(addr(0, 2), 32'h55);
    bus_read(addr(0, 2), rd); check("count_ro", rd, 32'd5);
    bus_write(addr(0, 5), 32'hAAAA);
    bus_read(addr(0, 5), rd); check("rsvd_off5", rd, 32'd0);

`ifdef MULTI_TIMER_PWM_EN
    // PWM: PRESET=9, COMPARE=3 -> high 3 of every 10 cycles
    begin
      int highs;
      bus_write(addr(0, 1), 32'd9);
      bus_write(addr(0, 4), 32'd3);
      bus_read(addr(0, 4), rd); check("cmp_rw", rd, 32'd3);
      bus_write(addr(0, 0), 32'h5);
      repeat (12) step();
      highs = 0;
      for (int k = 0; k < 20; k++) begin
        if (PWM_O[0]) highs++;
        step();
      end
      check("pwm_duty", 32'(highs), 32'd6);
      bus_write(addr(0, 0), 32'h0);
      bus_write(addr(0, 3), 32'd1);
    end
`else
    // MODE=10 is reserved: COUNT stays frozen; offset 4 reads 0
    bus_write(addr(0, 0), 32'h5);
    repeat (5) step();
    bus_read(addr(0, 2), rd); check("rsvd_mode_frozen", rd, 32'd5);
    bus_read(addr(0, 3), rd); check("rsvd_mode_noexp", rd, 32'd0);
    bus_write(addr(0, 4), 32'd7);
    bus_read(addr(0, 4), rd); check("off4_reads0", rd, 32'd0);
    bus_write(addr(0, 0), 32'h0);
`endif

    // asynchronous reset mid-count with IRQ pending
    bus_write(addr(1, 1), 32'd1);
    bus_write(addr(1, 0), 32'hB);
    repeat (4) step();
    check("ar_irq_before", {31'd0, IRQ}, 32'd1);
    #2;
    RST_I = 1'b1;
    #1;
    check("ar_irq", {31'd0, IRQ}, 32'd0);
    bus_read(addr(1, 2), rd); check("ar_count", rd, 32'd0);
    bus_read(addr(1, 0), rd); check("ar_ctrl", rd, 32'd0);
    bus_read(addr(1, 3), rd); check("ar_status", rd, 32'd0);
    step();
    RST_I = 1'b0;
    step();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
Parametrised multi-channel down-counter timer on the bridge bus. Each channel has a prescaler, one-shot and auto-reload modes, a sticky write-1-to-clear expiry flag and a per-channel interrupt mask. A single level IRQ goes to CP0. It is the successor to the single-channel timer and sits behind the bridge at a word-aligned base address.

Parameters:
NCH, 2, number of independent timer channels (1..8).
CNT_W, 32, counter/preset width in bits (8..32). Writes truncate to CNT_W bits; reads are zero-extended to 32 bits.
AW, $clog2(NCH)+3, word-address width (derived; do not override).

Ports:
CLK_I  in  1  clock.
RST_I  in  1  reset, asynchronous, active-high.
WE_I  in  1  write enable from bridge.
ADD_I  in  AW  word address [AW+1:2]. Upper bits select the channel; the low 3 bits select the register.
DAT_I  in  32  write data.
DAT_O  out  32  read data, combinational from ADD_I.
IRQ  out  1  level interrupt request, registered.

Behaviour:
- Register map per channel (offset = ADD_I[4:2]):
  - 0 CTRL.
  - 1 PRESET.
  - 2 COUNT (read-only; writes ignored).
  - 3 STATUS.
  - 4-7 reserved: read 0, writes ignored.
  - Channel index >= NCH: read 0, writes ignored.
- CTRL fields:
  - [0] EN.
  - [2:1] MODE: 00 one-shot, 01 auto-reload, 10/11 reserved (no counting).
  - [3] IM, interrupt mask (1 = enabled).
  - [15:8] PRESC.
  - Other bits read 0.
- STATUS[0] EXP: sticky expiry flag. Writing 1 clears it; writing 0 has no effect.
- Reset: all CTRL/PRESET/COUNT/STATUS = 0, prescaler counters = 0, IRQ = 0.
- Prescaler: per-channel 8-bit counter. A "tick" asserts when EN=1 and the prescaler equals PRESC; the prescaler then wraps to 0, otherwise it increments. PRESC=0 gives a tick every cycle.
- On tick with COUNT != 0: COUNT <= COUNT-1.
- On tick with COUNT == 0:
  - One-shot: EN <= 0, EXP <= 1; COUNT stays 0.
  - Auto-reload: COUNT <= PRESET, EXP <= 1.
- Auto-reload period = (PRESET+1)*(PRESC+1) cycles.
- Write to PRESET: COUNT <= DAT_I in the same edge and the prescaler clears. No tick is evaluated that cycle.
- Write to CTRL: new value is effective from the next edge. An EN 0->1 transition clears the prescaler.
- Simultaneous events on the same edge:
  - Hardware EXP set and W1C clear: set wins.
  - Hardware EN clear (one-shot expiry) and CTRL write: the CTRL write wins.
- IRQ <= OR over channels of (EXP & IM), registered, one cycle after EXP/IM change. It stays high until software clears every enabled EXP or masks it.
- Reset mid-count aborts immediately; all state returns to reset values asynchronously.

Optional Feature:
MULTI_TIMER_PWM_EN.
- Defined:
  - MODE=10 is PWM: it counts and reloads exactly as auto-reload and sets EXP on reload.
  - Offset 4 is COMPARE (CNT_W bits, R/W, reset 0).
  - Extra port PWM_O out NCH: PWM_O[i] <= EN & (COUNT < COMPARE), registered, reset 0.
- Undefined: MODE=10 is reserved (no counting), offset 4 reads 0, and the PWM_O port is absent.

Decomposition:
- Package multi_timer_pkg holds:
  - register offset constants (REG_CTRL=0 .. REG_CMP=4);
  - CTRL bit positions (EN, MODE lsb/msb, IM, PRESC lsb/msb);
  - mode encodings (MODE_ONESHOT, MODE_RELOAD, MODE_PWM).
- Sub-module multi_timer_chan is one channel: registers, prescaler, counter, EXP and PWM.
- Top level does channel/offset decode, the read mux, and the IRQ OR/register.

Test Plan:
- Reset, then read all offsets of ch0/ch1 -> all 0; IRQ=0.
- ch0 PRESET=3, CTRL=0x9 (EN, one-shot, IM) -> COUNT 3,2,1,0 on successive cycles; EXP=1 on the 5th edge after enable; EN reads 0; IRQ=1 one cycle later. Write STATUS=1 -> IRQ=0.
- ch1 PRESET=2, CTRL=0x0403 (reload, PRESC=4, IM=0) -> EXP sets every 15 cycles; IRQ stays 0. Then set IM -> IRQ=1.
- Hardware EXP set coincident with a W1C write to STATUS -> EXP reads 1 afterwards.
- Write PRESET=100 mid-count -> COUNT reads 100 next cycle; the prescaler restarts from 0.
- With MULTI_TIMER_PWM_EN: PRESET=9, COMPARE=3, MODE=10 -> PWM_O high 3 of every 10 cycles. Without the macro: MODE=10 leaves COUNT frozen.
